// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Optional WAIT_LOCK timeout is enabled by defining RST_SEQ_TIMEOUT_EN.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int ABORT_CNT_W = 8;
    localparam logic [ABORT_CNT_W-1:0] ABORT_CNT_MAX = '1;

    // Counter width able to hold values 0..max_count without wrapping.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) + 1 : 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_lock_filter.sv
// PLL lock qualifier: 2-FF synchronizer followed by a run-length filter.
// lock_ok rises after LOCK_FILT consecutive synced-high cycles and drops on the first synced-low one.
module lock_filter
    import rst_seq_pkg::*;
#(
    parameter int LOCK_FILT = 8
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int FILT_W = cnt_width(LOCK_FILT);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

    logic [1:0]        sync_reg;
    logic [FILT_W-1:0] run_cnt_reg;
    logic              lock_ok_reg;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_reg    <= 2'b00;
            run_cnt_reg <= '0;
            lock_ok_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
            if (!sync_reg[1]) begin
                run_cnt_reg <= '0;
                lock_ok_reg <= 1'b0;
            end else if (run_cnt_reg == FILT_LAST) begin
                lock_ok_reg <= 1'b1;
            end else begin
                run_cnt_reg <= run_cnt_reg + 1'b1;
            end
        end
    end

    // Gate with the synced level so a lock drop is visible in the very cycle it is seen.
    assign lock_ok = lock_ok_reg & sync_reg[1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: HOLD, wait for qualified PLL lock, release stages in order, abort on loss.
// Define RST_SEQ_TIMEOUT_EN to add the WAIT_LOCK timeout and the sticky lock_timeout port.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 32,
    parameter int STAGE_GAP   = 16,
    parameter int LOCK_FILT   = 8
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                   clk,
    input  logic                   async_rst_n,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic [NUM_STAGES-1:0]  stage_rst_n,
    output logic                   seq_done,
    output logic                   seq_busy,
    output logic [ABORT_CNT_W-1:0] abort_cnt
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    output logic                   lock_timeout
`endif
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(STAGE_GAP);
    localparam int IDX_W  = cnt_width(NUM_STAGES);

    localparam logic [HOLD_W-1:0]     HOLD_LAST     = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST      = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST_STEP = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);
    localparam logic [NUM_STAGES-1:0] FIRST_MASK    = NUM_STAGES'(1);

    seq_state_t                state_reg;
    logic [HOLD_W-1:0]         hold_cnt_reg;
    logic [GAP_W-1:0]          gap_cnt_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic [NUM_STAGES-1:0]     stage_rst_n_reg;
    logic                      seq_done_reg;
    logic                      seq_busy_reg;
    logic [ABORT_CNT_W-1:0]    abort_cnt_reg;
    logic                      lock_ok;
    logic                      abort;
    logic [NUM_STAGES-1:0]     step_mask;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int WAIT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              lock_timeout_reg;

    assign lock_timeout = lock_timeout_reg;
`endif

    lock_filter #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_filter (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .pll_locked  (pll_locked),
        .lock_ok     (lock_ok)
    );

    // Thermometer mask for the next release step: bits 0..idx+1 released.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_step_mask
            assign step_mask[gi] = (gi <= int'(idx_reg) + 1);
        end
    endgenerate

    assign abort = ((state_reg == RELEASE) || (state_reg == RUN)) && (!lock_ok || soft_rst_req);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_reg        <= HOLD;
            hold_cnt_reg     <= '0;
            gap_cnt_reg      <= '0;
            idx_reg          <= '0;
            stage_rst_n_reg  <= '0;
            seq_done_reg     <= 1'b0;
            seq_busy_reg     <= 1'b1;
            abort_cnt_reg    <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
            wait_cnt_reg     <= '0;
            lock_timeout_reg <= 1'b0;
`endif
        end else if (abort) begin
            state_reg       <= HOLD;
            hold_cnt_reg    <= '0;
            gap_cnt_reg     <= '0;
            idx_reg         <= '0;
            stage_rst_n_reg <= '0;
            seq_done_reg    <= 1'b0;
            seq_busy_reg    <= 1'b1;
            if (abort_cnt_reg != ABORT_CNT_MAX) begin
                abort_cnt_reg <= abort_cnt_reg + 1'b1;
            end
        end else begin
            case (state_reg)
                HOLD: begin
                    if (soft_rst_req) begin
                        hold_cnt_reg <= '0;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= WAIT_LOCK;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (soft_rst_req) begin
                        state_reg <= HOLD;
`ifdef RST_SEQ_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end else if (lock_ok) begin
                        stage_rst_n_reg <= FIRST_MASK;
                        idx_reg         <= '0;
                        gap_cnt_reg     <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
                        wait_cnt_reg    <= '0;
`endif
                        if (NUM_STAGES == 1) begin
                            state_reg    <= RUN;
                            seq_done_reg <= 1'b1;
                            seq_busy_reg <= 1'b0;
                        end else begin
                            state_reg <= RELEASE;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (wait_cnt_reg == WAIT_LAST) begin
                        wait_cnt_reg     <= '0;
                        lock_timeout_reg <= 1'b1;
                        state_reg        <= HOLD;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end

                RELEASE: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg     <= '0;
                        idx_reg         <= idx_reg + 1'b1;
                        stage_rst_n_reg <= step_mask;
                        if (idx_reg == IDX_LAST_STEP) begin
                            state_reg    <= RUN;
                            seq_done_reg <= 1'b1;
                            seq_busy_reg <= 1'b0;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end

                RUN: begin
                    state_reg <= RUN;
                end

                default: begin
                    state_reg <= HOLD;
                end
            endcase
        end
    end

    assign stage_rst_n = stage_rst_n_reg;
    assign seq_done    = seq_done_reg;
    assign seq_busy    = seq_busy_reg;
    assign abort_cnt   = abort_cnt_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with default parameters; edges are counted from reset release.
module tb_rst_sequencer;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic [NS-1:0] stage_rst_n;
    logic          seq_done;
    logic          seq_busy;
    logic [7:0]    abort_cnt;

    int edge_num = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_STAGES  (NS),
        .HOLD_CYCLES (32),
        .STAGE_GAP   (16),
        .LOCK_FILT   (8)
    ) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (stage_rst_n),
        .seq_done     (seq_done),
        .seq_busy     (seq_busy),
        .abort_cnt    (abort_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_num, got, exp);
        end else begin
            $display("ok   %s @edge %0d: %0h", tag, edge_num, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_num++;
    endtask

    task automatic run_to(input int n);
        while (edge_num < n) tick();
    endtask

    // Release reset just after a clock edge; that edge is edge 0.
    task automatic release_reset();
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        edge_num    = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values with pll_locked high from the start
        pll_locked = 1'b1;
        #12;
        check_eq("rst_stage", stage_rst_n, 4'h0);
        check_eq("rst_done",  seq_done,    1'b0);
        check_eq("rst_busy",  seq_busy,    1'b1);
        check_eq("rst_abort", abort_cnt,   8'd0);

        // Sequence with lock present: releases at 33, 49, 65, 81
        release_reset();
        run_to(32); check_eq("t1_stage", stage_rst_n, 4'h0);
        run_to(33); check_eq("t1_stage", stage_rst_n, 4'h1);
                    check_eq("t1_busy",  seq_busy,    1'b1);
        run_to(48); check_eq("t1_stage", stage_rst_n, 4'h1);
        run_to(49); check_eq("t1_stage", stage_rst_n, 4'h3);
        run_to(64); check_eq("t1_stage", stage_rst_n, 4'h3);
        run_to(65); check_eq("t1_stage", stage_rst_n, 4'h7);
        run_to(80); check_eq("t1_stage", stage_rst_n, 4'h7);
                    check_eq("t1_done",  seq_done,    1'b0);
        run_to(81); check_eq("t1_stage", stage_rst_n, 4'hf);
                    check_eq("t1_done",  seq_done,    1'b1);
                    check_eq("t1_busy",  seq_busy,    1'b0);

        // Asynchronous reset in RUN clears outputs without a clock edge
        run_to(90);
        #2;
        async_rst_n = 1'b0;
        pll_locked  = 1'b0;
        #1;
        check_eq("arst_stage", stage_rst_n, 4'h0);
        check_eq("arst_done",  seq_done,    1'b0);
        check_eq("arst_busy",  seq_busy,    1'b1);

        // Late lock: pll_locked rises after edge 100, lock_ok at 110, releases from 111
        release_reset();
        run_to(50);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_eq("wl_soft_abort", abort_cnt,   8'd0);
        check_eq("wl_soft_busy",  seq_busy,    1'b1);
        check_eq("wl_soft_stage", stage_rst_n, 4'h0);
        run_to(100);
        pll_locked = 1'b1;
        run_to(110); check_eq("t2_stage", stage_rst_n, 4'h0);
        run_to(111); check_eq("t2_stage", stage_rst_n, 4'h1);
        run_to(126); check_eq("t2_stage", stage_rst_n, 4'h1);
        run_to(127); check_eq("t2_stage", stage_rst_n, 4'h3);
        run_to(143); check_eq("t2_stage", stage_rst_n, 4'h7);
        run_to(158); check_eq("t2_done",  seq_done,    1'b0);
        run_to(159); check_eq("t2_stage", stage_rst_n, 4'hf);
                     check_eq("t2_done",  seq_done,    1'b1);
                     check_eq("t2_busy",  seq_busy,    1'b0);

        // One-cycle lock drop in RUN: seen at 172 after sync, abort at 173
        run_to(170);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        run_to(172); check_eq("t3_stage", stage_rst_n, 4'hf);
        run_to(173); check_eq("t3_stage", stage_rst_n, 4'h0);
                     check_eq("t3_done",  seq_done,    1'b0);
                     check_eq("t3_busy",  seq_busy,    1'b1);
                     check_eq("t3_abort", abort_cnt,   8'd1);
        run_to(205); check_eq("t3_stage", stage_rst_n, 4'h0);
        run_to(206); check_eq("t3_stage", stage_rst_n, 4'h1);
        run_to(222); check_eq("t3_stage", stage_rst_n, 4'h3);

        // Soft request in the same cycle as lock loss during RELEASE: one abort
        run_to(226);
        pll_locked = 1'b0;
        run_to(228); check_eq("t4_stage", stage_rst_n, 4'h3);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_eq("t4_stage", stage_rst_n, 4'h0);
        check_eq("t4_abort", abort_cnt,   8'd2);
        check_eq("t4_busy",  seq_busy,    1'b1);
        run_to(240); check_eq("t4_abort_hold", abort_cnt, 8'd2);
        pll_locked = 1'b1;

        // Repeated soft aborts from RUN: count saturates at 255
        for (int k = 1; k <= 300; k++) begin
            int guard;
            guard = 0;
            while (seq_done !== 1'b1 && guard < 300) begin
                tick();
                guard++;
            end
            if (seq_done !== 1'b1) begin
                check_eq("sat_reach_run", seq_done, 1'b1);
                break;
            end
            soft_rst_req = 1'b1;
            tick();
            soft_rst_req = 1'b0;
            if (k == 1) check_eq("sat_stage", stage_rst_n, 4'h0);
            if (k == 252) check_eq("sat_abort", abort_cnt, 8'd254);
            if (k == 253) check_eq("sat_abort", abort_cnt, 8'd255);
            if (k == 300) check_eq("sat_abort", abort_cnt, 8'd255);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
